// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues one imem read at a time at the fetch PC,
// buffers {pc, inst} pairs for the decoder, and redirects on backend flushes
// or on decoder-predicted control flow.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | first cycle after reset, no request yet
// S_FETCH | read request pending at fetch_pc, a buffer slot is reserved for it
// S_HOLD  | buffer full, no request
// S_FLUSH | old request still in flight after a redirect; its data is dropped
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h1eceb000,
    parameter int          FBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [31:0]                   o_imem_addr,
    output logic [3:0]                    o_imem_rmask,
    input  logic [31:0]                   i_imem_rdata,
    input  logic                          i_imem_resp,
    output logic                          o_dec_valid,
    output logic [31:0]                   o_dec_inst,
    output logic [31:0]                   o_dec_pc,
    input  logic [31:0]                   i_dec_pc_next,
    input  logic                          i_dec_ready,
    input  logic                          i_redirect_valid,
    input  logic [31:0]                   i_redirect_pc,
    output logic [$clog2(FBUF_DEPTH):0]   o_fbuf_count
);

    localparam int             PW   = $clog2(FBUF_DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(FBUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_nxt;
    logic [31:0]     r_imem_addr;
    logic [31:0]     w_imem_addr_nxt;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_after;
    logic [CW-1:0]   w_count_nxt;
    logic [31:0]     r_buf_pc   [FBUF_DEPTH];
    logic [31:0]     r_buf_inst [FBUF_DEPTH];

    logic            w_pending;
    logic            w_dec_valid;
    logic            w_pop;
    logic            w_dec_redir;
    logic            w_redir;
    logic [31:0]     w_target;
    logic            w_push;
    logic [31:0]     w_head_pc;

    assign w_head_pc   = r_buf_pc[r_rd_ptr];
    assign w_pending   = (r_state == S_FETCH) || (r_state == S_FLUSH);
    assign w_dec_valid = (r_count != '0);
    assign w_pop       = w_dec_valid & i_dec_ready;
    // The head is still popped on a decoder redirect; only younger entries are lost.
    assign w_dec_redir = w_pop & (i_dec_pc_next != (w_head_pc + 32'd4)) & ~i_redirect_valid;
    assign w_redir     = i_redirect_valid | w_dec_redir;
    assign w_target    = i_redirect_valid ? i_redirect_pc : i_dec_pc_next;
    // A response arriving on a redirect cycle belongs to the squashed path.
    assign w_push      = (r_state == S_FETCH) & i_imem_resp & ~w_redir;

    // Occupancy after this cycle's push/pop, ignoring redirect clearing.
    always_comb begin
        w_count_after = r_count;
        if (w_push) begin
            w_count_after = w_count_after + CW'(1);
        end
        if (w_pop) begin
            w_count_after = w_count_after - CW'(1);
        end
    end

    // Next-state, fetch PC and request address selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_count_nxt    = w_redir ? '0 : w_count_after;

        if (w_redir) begin
            w_fetch_pc_nxt = w_target;
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_redir) begin
                    w_state_nxt = i_imem_resp ? S_FETCH : S_FLUSH;
                end else if (i_imem_resp && (w_count_after == FULL)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir || (w_count_after < FULL)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FLUSH: begin
                // A redirect here only retargets fetch_pc; the old request must still drain.
                if (i_imem_resp) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The bus address stays on the in-flight request while it is being flushed.
        w_imem_addr_nxt = (w_state_nxt == S_FLUSH) ? r_imem_addr : w_fetch_pc_nxt;
    end

    // State, PC, address and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_imem_addr <= w_imem_addr_nxt;
            r_count     <= w_count_nxt;
        end
    end

    // Buffer pointers; a redirect empties the buffer by rewinding both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_redir) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Buffer storage; contents are qualified by the count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
            r_buf_inst[r_wr_ptr] <= i_imem_rdata;
        end
    end

    assign o_imem_addr  = r_imem_addr;
    assign o_imem_rmask = w_pending ? 4'hf : 4'h0;
    assign o_dec_valid  = w_dec_valid;
    assign o_dec_pc     = w_head_pc;
    assign o_dec_inst   = r_buf_inst[r_rd_ptr];
    assign o_fbuf_count = r_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a transaction-level model: a queue of
// buffered {pc, inst} entries, the fetch PC and a "draining a squashed request" flag.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] o_imem_addr;
    logic [3:0]  o_imem_rmask;
    logic [31:0] i_imem_rdata;
    logic        i_imem_resp;
    logic        o_dec_valid;
    logic [31:0] o_dec_inst;
    logic [31:0] o_dec_pc;
    logic [31:0] i_dec_pc_next;
    logic        i_dec_ready;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [2:0]  o_fbuf_count;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .FBUF_DEPTH (DEPTH)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_imem_addr      (o_imem_addr),
        .o_imem_rmask     (o_imem_rmask),
        .i_imem_rdata     (i_imem_rdata),
        .i_imem_resp      (i_imem_resp),
        .o_dec_valid      (o_dec_valid),
        .o_dec_inst       (o_dec_inst),
        .o_dec_pc         (o_dec_pc),
        .i_dec_pc_next    (i_dec_pc_next),
        .i_dec_ready      (i_dec_ready),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_fbuf_count     (o_fbuf_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_flush_addr;
    bit          m_flushing;
    bit          m_started;

    bit          rsp_active;
    int          rsp_wait;

    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc   = RESET_PC;
        m_flush_addr = RESET_PC;
        m_flushing   = 1'b0;
        m_started    = 1'b0;
        rsp_active   = 1'b0;
        rsp_wait     = 0;
    endtask

    // A request is outstanding while draining a squashed one, or whenever
    // fetch has started and the buffer has a free slot.
    function automatic bit m_pending();
        return m_flushing || (m_started && (m_q.size() < DEPTH));
    endfunction

    task automatic check_outputs();
        chk("rmask", 32'(o_imem_rmask), m_pending() ? 32'hf : 32'h0);
        chk("addr", o_imem_addr, m_flushing ? m_flush_addr : m_fetch_pc);
        chk("dec_valid", 32'(o_dec_valid), (m_q.size() != 0) ? 32'd1 : 32'd0);
        chk("fbuf_count", 32'(o_fbuf_count), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("dec_pc", o_dec_pc, m_q[0].pc);
            chk("dec_inst", o_dec_inst, m_q[0].inst);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0:       t = 32'h0000_0080;
            1:       t = 32'hffff_fff0;
            2:       t = 32'h1ecf_0000;
            3:       t = 32'h1eceb100;
            default: t = $urandom & 32'hffff_fffc;
        endcase
        return t;
    endfunction

    task automatic drive(input int ready_pct, input int redir_pct, input int mispred_pct);
        i_dec_ready = ($urandom_range(0, 99) < ready_pct);
        if ((m_q.size() != 0) && ($urandom_range(0, 99) < mispred_pct)) begin
            i_dec_pc_next = pick_target();
        end else if (m_q.size() != 0) begin
            i_dec_pc_next = m_q[0].pc + 32'd4;
        end else begin
            i_dec_pc_next = $urandom;
        end
        i_redirect_valid = ($urandom_range(0, 99) < redir_pct);
        i_redirect_pc    = pick_target();
        i_imem_resp      = 1'b0;
        i_imem_rdata     = $urandom;
        if (o_imem_rmask == 4'hf) begin
            if (!rsp_active) begin
                rsp_active = 1'b1;
                rsp_wait   = $urandom_range(0, 3);
            end
            if (rsp_wait == 0) begin
                i_imem_resp = 1'b1;
                rsp_active  = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit          pend;
        bit          pop;
        bit          dredir;
        logic [31:0] tgt;
        pend   = m_pending();
        pop    = (m_q.size() != 0) && i_dec_ready;
        dredir = pop && !i_redirect_valid && (i_dec_pc_next != (m_q[0].pc + 32'd4));
        if (i_redirect_valid || dredir) begin
            tgt = i_redirect_valid ? i_redirect_pc : i_dec_pc_next;
            m_q.delete();
            if (m_flushing) begin
                if (i_imem_resp) m_flushing = 1'b0;
            end else if (pend && !i_imem_resp) begin
                m_flushing   = 1'b1;
                m_flush_addr = m_fetch_pc;
            end
            m_fetch_pc = tgt;
        end else if (m_flushing) begin
            if (i_imem_resp) m_flushing = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (pend && i_imem_resp) begin
                m_q.push_back('{pc: m_fetch_pc, inst: i_imem_rdata});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        m_started = 1'b1;
    endtask

    task automatic run(input int n, input int ready_pct, input int redir_pct, input int mispred_pct);
        for (int i = 0; i < n; i++) begin
            check_outputs();
            drive(ready_pct, redir_pct, mispred_pct);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        i_imem_rdata     = '0;
        i_imem_resp      = 1'b0;
        i_dec_pc_next    = '0;
        i_dec_ready      = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Sequential fetch with an always-ready queue.
        run(60, 100, 0, 0);
        // Back-pressure until the buffer fills and fetch holds.
        run(30, 0, 0, 0);
        // Mixed traffic: stalls, flushes, decoder redirects, PC wrap targets.
        run(3000, 60, 5, 10);

        // Reset while a squashed request is draining, if one shows up.
        guard = 0;
        while (!m_flushing && guard < 400) begin
            run(1, 50, 15, 10);
            guard++;
        end
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_rmask", 32'(o_imem_rmask), 32'h0);
        chk("rst_valid", 32'(o_dec_valid), 32'h0);
        chk("rst_count", 32'(o_fbuf_count), 32'h0);
        chk("rst_addr", o_imem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        run(1500, 80, 3, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
